// File: rtl/phase_seq_pkg.sv
// ---------------------------------------------------------------------------
// phase_seq_pkg
//
// Definitions shared by the phase sequencer and the downstream control
// decoder: the sequencer state encoding, the idle phase value, and the
// opcode fields that identify the HLT instruction.
//
// Contents:
//   seq_state_t  - sequencer state (IDLE, RUN, HALT)
//   PHASE_IDLE   - phase value presented while not executing
//   OP_ALU       - instruction[15:14] value for the ALU group
//   ALU_HLT      - instruction[7:4] value selecting HLT within the ALU group
//   is_hlt()     - decodes HLT from a full 16-bit instruction word
// ---------------------------------------------------------------------------
package phase_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } seq_state_t;

   localparam logic [2:0] PHASE_IDLE = 3'd0;

   localparam logic [1:0] OP_ALU  = 2'b11;
   localparam logic [3:0] ALU_HLT = 4'b1111;

   // HLT lives in the ALU opcode group with a dedicated function field
   function automatic logic is_hlt(input logic [15:0] instr);
      return (instr[15:14] == OP_ALU) && (instr[7:4] == ALU_HLT);
   endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// phase_sequencer_if
//
// Bundle of the front-panel, IR and phase signals exchanged between the
// phase sequencer and its surroundings.
//
// Parameters:
//   CNT_W        - width of the retired-instruction counter
//
// Signals:
//   exec_btn     - raw exec button level (asynchronous)
//   step_btn     - raw step button level (only with PHASE_SEQ_STEP_EN)
//   instruction  - IR contents, valid from phase 2 onward
//   phase        - current phase, 0 while idle or halted
//   running      - sequencer is executing instructions
//   halted       - sequencer stopped on HLT
//   inst_cnt     - retired-instruction count
//
// Modports:
//   master       - drives buttons and IR, observes sequencer outputs
//   slave        - the sequencer itself
//
// Configuration macro: PHASE_SEQ_STEP_EN adds the step_btn signal.
// ---------------------------------------------------------------------------
interface phase_sequencer_if #(
   parameter int CNT_W = 16
);

   logic             exec_btn;
`ifdef PHASE_SEQ_STEP_EN
   logic             step_btn;
`endif
   logic [15:0]      instruction;
   logic [2:0]       phase;
   logic             running;
   logic             halted;
   logic [CNT_W-1:0] inst_cnt;

   modport master (
`ifdef PHASE_SEQ_STEP_EN
      output step_btn,
`endif
      output exec_btn,
      output instruction,
      input  phase,
      input  running,
      input  halted,
      input  inst_cnt
   );

   modport slave (
`ifdef PHASE_SEQ_STEP_EN
      input  step_btn,
`endif
      input  exec_btn,
      input  instruction,
      output phase,
      output running,
      output halted,
      output inst_cnt
   );

endinterface

// File: rtl/btn_edge_sync.sv
// ---------------------------------------------------------------------------
// btn_edge_sync
//
// Brings an asynchronous push-button level into the clock domain through a
// two-flop synchroniser and turns each rising edge into a single-cycle pulse.
//
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset, clears all flops
//   btn    - raw button level
//   pulse  - high for one cycle after each synchronised rising edge
//
// Latency: a level first sampled high at edge k gives a pulse during the
// cycle that follows edge k+1.
// ---------------------------------------------------------------------------
module btn_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // meta_q may go metastable; only sync_q and its delayed copy are used
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= btn;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
//
// Drives the 3-bit phase that steps the control decoder through each
// instruction (phases 1..NUM_PHASES), holding phase 0 while idle or halted.
// The exec button toggles run/stop; a stop request lets the current
// instruction finish. HLT in the IR, seen at phase 2, halts the machine.
// Every retired instruction (including HLT) bumps inst_cnt.
//
// Parameters:
//   NUM_PHASES   - phases per instruction, legal range 2..7
//   CNT_W        - retired-instruction counter width (must match bus)
//
// Ports:
//   clk          - system clock
//   rst_n        - asynchronous active-low reset
//   bus          - phase_sequencer_if.slave: buttons, IR and outputs
//
// All outputs are registered.
//
// Configuration macro: PHASE_SEQ_STEP_EN enables the step button, which
// runs exactly one instruction from IDLE or HALT.
// ---------------------------------------------------------------------------
module phase_sequencer
   import phase_seq_pkg::*;
#(
   parameter int NUM_PHASES = 5,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   phase_sequencer_if.slave  bus
);

   localparam logic [2:0] FIRST_PHASE = 3'd1;
   localparam logic [2:0] HLT_PHASE   = 3'd2;
   localparam logic [2:0] LAST_PHASE  = 3'(NUM_PHASES);

   seq_state_t       state_q;
   seq_state_t       state_d;
   logic [2:0]       phase_q;
   logic [2:0]       phase_d;
   logic             stop_req_q;
   logic             stop_req_d;
   logic             running_q;
   logic             running_d;
   logic             halted_q;
   logic             halted_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             exec_p;

   btn_edge_sync u_exec_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (bus.exec_btn),
      .pulse (exec_p)
   );

`ifdef PHASE_SEQ_STEP_EN
   logic step_p;
   logic step_mode_q;
   logic step_mode_d;

   btn_edge_sync u_step_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (bus.step_btn),
      .pulse (step_p)
   );
`endif

   // Next-state logic. stop_req is a toggle: each exec pulse during RUN
   // flips it, and the sequencer only acts on it at the final phase so
   // that an instruction is never cut short. A pending request at the final
   // phase wins over a simultaneous pulse, which is then simply consumed.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      stop_req_d  = stop_req_q;
      cnt_d       = cnt_q;
`ifdef PHASE_SEQ_STEP_EN
      step_mode_d = step_mode_q;
`endif

      unique case (state_q)
         IDLE, HALT: begin
            if (exec_p) begin
               state_d     = RUN;
               phase_d     = FIRST_PHASE;
               stop_req_d  = 1'b0;
`ifdef PHASE_SEQ_STEP_EN
               step_mode_d = 1'b0;
            end else if (step_p) begin
               state_d     = RUN;
               phase_d     = FIRST_PHASE;
               stop_req_d  = 1'b0;
               step_mode_d = 1'b1;
`endif
            end
         end

         RUN: begin
            if ((phase_q == HLT_PHASE) && is_hlt(bus.instruction)) begin
               // HLT beats any exec pulse arriving in the same cycle
               state_d     = HALT;
               phase_d     = PHASE_IDLE;
               stop_req_d  = 1'b0;
               cnt_d       = cnt_q + CNT_W'(1);
`ifdef PHASE_SEQ_STEP_EN
               step_mode_d = 1'b0;
`endif
            end else if (phase_q == LAST_PHASE) begin
               cnt_d = cnt_q + CNT_W'(1);
`ifdef PHASE_SEQ_STEP_EN
               if (stop_req_q || step_mode_q) begin
`else
               if (stop_req_q) begin
`endif
                  state_d     = IDLE;
                  phase_d     = PHASE_IDLE;
                  stop_req_d  = 1'b0;
`ifdef PHASE_SEQ_STEP_EN
                  step_mode_d = 1'b0;
`endif
               end else begin
                  // a pulse here defers the stop to the next instruction
                  phase_d    = FIRST_PHASE;
                  stop_req_d = exec_p;
               end
            end else begin
               phase_d = phase_q + 3'd1;
               if (exec_p) begin
                  stop_req_d = ~stop_req_q;
               end
            end
         end

         default: begin
            state_d    = IDLE;
            phase_d    = PHASE_IDLE;
            stop_req_d = 1'b0;
`ifdef PHASE_SEQ_STEP_EN
            step_mode_d = 1'b0;
`endif
         end
      endcase

      running_d = (state_d == RUN);
      halted_d  = (state_d == HALT);
   end

   // State and output registers; reset abandons any instruction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         phase_q    <= PHASE_IDLE;
         stop_req_q <= 1'b0;
         running_q  <= 1'b0;
         halted_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         stop_req_q <= stop_req_d;
         running_q  <= running_d;
         halted_q   <= halted_d;
         cnt_q      <= cnt_d;
      end
   end

`ifdef PHASE_SEQ_STEP_EN
   // Remembers that the current run was started by a single step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_mode_q <= 1'b0;
      end else begin
         step_mode_q <= step_mode_d;
      end
   end
`endif

   assign bus.phase    = phase_q;
   assign bus.running  = running_q;
   assign bus.halted   = halted_q;
   assign bus.inst_cnt = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phase_sequencer
//
// Directed bench for phase_sequencer (NUM_PHASES=5, narrow 4-bit counter so
// the counter wrap is reachable quickly). A behavioural model tracks the
// expected outputs from the button sample history and the instruction rules;
// a compare process checks it against the DUT on every falling edge, and the
// stimulus sequence pins the model with hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_phase_sequencer;

   localparam int NP = 5;
   localparam int CW = 4;
   localparam logic [15:0] ADD = 16'hC000;
   localparam logic [15:0] HLT = 16'hC0F0;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   bit   cmp_en = 1'b0;

   phase_sequencer_if #(.CNT_W(CW)) bus ();

   phase_sequencer #(.NUM_PHASES(NP), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model. A button level sampled at edge n acts on the
   // sequencer at edge n+2, so pulse at edge n = s[n-2] & ~s[n-3].
   int m_pos = 0;
   bit m_halted = 0;
   bit m_stop = 0;
   bit m_single = 0;
   int m_count = 0;
   bit e1 = 0, e2 = 0, e3 = 0;
   bit t1 = 0, t2 = 0, t3 = 0;

   always @(posedge clk or negedge rst_n) begin
      bit ex, st, hl;
      if (!rst_n) begin
         m_pos = 0; m_halted = 0; m_stop = 0; m_single = 0; m_count = 0;
         e1 = 0; e2 = 0; e3 = 0; t1 = 0; t2 = 0; t3 = 0;
      end else begin
         ex = e2 && !e3;
         st = t2 && !t3;
         e3 = e2; e2 = e1; e1 = bus.exec_btn;
`ifdef PHASE_SEQ_STEP_EN
         t3 = t2; t2 = t1; t1 = bus.step_btn;
`else
         st = 0;
`endif
         hl = (bus.instruction[15:14] == 2'd3) && (bus.instruction[7:4] == 4'd15);
         if (m_pos == 0) begin
            if (ex || st) begin
               m_pos = 1; m_halted = 0; m_stop = 0; m_single = !ex;
            end
         end else if (m_pos == 2 && hl) begin
            m_count = (m_count + 1) % (1 << CW);
            m_pos = 0; m_halted = 1; m_stop = 0; m_single = 0;
         end else if (m_pos == NP) begin
            m_count = (m_count + 1) % (1 << CW);
            if (m_stop || m_single) begin
               m_pos = 0; m_stop = 0; m_single = 0;
            end else begin
               m_pos = 1; m_stop = ex;
            end
         end else begin
            m_pos = m_pos + 1;
            if (ex) m_stop = !m_stop;
         end
      end
   end

   // Model-vs-DUT compare on every falling edge
   always @(negedge clk) begin
      if (cmp_en) begin
         checks++;
         if (int'(bus.phase) != m_pos || bus.running != (m_pos != 0) ||
             bus.halted != m_halted || int'(bus.inst_cnt) != m_count) begin
            errors++;
            $display("[TB] FAIL model_cmp t=%0t got ph=%0d run=%0b hlt=%0b cnt=%0d exp ph=%0d run=%0b hlt=%0b cnt=%0d",
                     $time, bus.phase, bus.running, bus.halted, bus.inst_cnt,
                     m_pos, (m_pos != 0), m_halted, m_count);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input bit exec, input logic [15:0] instr);
      bus.exec_btn    = exec;
      bus.instruction = instr;
   endtask

   task automatic checkOutput(input string name, input int ph, input bit run,
                              input bit hlt, input int cnt);
      checks++;
      if (int'(bus.phase) != ph || bus.running != run || bus.halted != hlt ||
          int'(bus.inst_cnt) != cnt) begin
         errors++;
         $display("[TB] FAIL %s got ph=%0d run=%0b hlt=%0b cnt=%0d exp ph=%0d run=%0b hlt=%0b cnt=%0d",
                  name, bus.phase, bus.running, bus.halted, bus.inst_cnt,
                  ph, run, hlt, cnt);
      end
   endtask

   // Exec press long enough to be sampled twice; returns on the falling
   // edge after the pulse has moved the sequencer.
   task automatic pressExec(input logic [15:0] instr);
      applyStimulus(1'b1, instr);
      tick();
      tick();
      applyStimulus(1'b0, instr);
      tick();
   endtask

   initial begin
      int seq[4] = '{2, 3, 4, 5};
      rst_n = 1'b1;
`ifdef PHASE_SEQ_STEP_EN
      bus.step_btn = 1'b0;
`endif
      applyStimulus(1'b0, ADD);
      #3 rst_n = 1'b0;
      repeat (3) tick();
      checkOutput("reset", 0, 0, 0, 0);
      cmp_en = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();

      // plain run: phases 1..5 then wrap
      $display("[TB] run from idle");
      applyStimulus(1'b1, ADD);
      tick();
      checkOutput("sync_delay1", 0, 0, 0, 0);
      tick();
      checkOutput("sync_delay2", 0, 0, 0, 0);
      applyStimulus(1'b0, ADD);
      tick();
      checkOutput("first_phase", 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("phase_seq", seq[i], 1, 0, 0);
      end
      tick();
      checkOutput("first_wrap", 1, 1, 0, 1);

      // HLT seen at phase 2
      $display("[TB] halt");
      applyStimulus(1'b0, HLT);
      tick();
      checkOutput("hlt_phase2", 2, 1, 0, 1);
      tick();
      checkOutput("halted", 0, 0, 1, 2);
      tick();
      pressExec(ADD);
      checkOutput("resume_from_halt", 1, 1, 0, 2);

      // exec mid-instruction: completes then stops
      $display("[TB] stop request");
      applyStimulus(1'b1, ADD);
      tick();
      tick();
      applyStimulus(1'b0, ADD);
      tick();
      checkOutput("stop_pending_ph4", 4, 1, 0, 2);
      tick();
      tick();
      checkOutput("stopped", 0, 0, 0, 3);
      tick();
      pressExec(ADD);
      checkOutput("resume_from_idle", 1, 1, 0, 3);

      // two presses within one instruction cancel each other
      $display("[TB] double press");
      tick();
      tick();
      tick();
      applyStimulus(1'b1, ADD);
      tick();
      applyStimulus(1'b0, ADD);
      tick();
      checkOutput("wrap_before_presses", 1, 1, 0, 4);
      tick();
      applyStimulus(1'b1, ADD);
      tick();
      applyStimulus(1'b0, ADD);
      tick();
      tick();
      tick();
      checkOutput("two_presses_no_stop", 1, 1, 0, 5);

      // exec pulse coinciding with HLT at phase 2
      $display("[TB] exec with hlt");
      repeat (4) tick();
      applyStimulus(1'b1, HLT);
      tick();
      applyStimulus(1'b0, HLT);
      checkOutput("pre_hlt_wrap", 1, 1, 0, 6);
      tick();
      tick();
      checkOutput("halt_beats_exec", 0, 0, 1, 7);
      applyStimulus(1'b0, ADD);
      tick();
      pressExec(ADD);
      checkOutput("resume_after_hlt", 1, 1, 0, 7);
      repeat (5) tick();
      checkOutput("no_stale_stop", 1, 1, 0, 8);

      // asynchronous reset mid-instruction
      $display("[TB] async reset");
      repeat (3) tick();
      checkOutput("before_reset_ph4", 4, 1, 0, 8);
      #2 rst_n = 1'b0;
      #1 checkOutput("async_reset", 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // counter wrap at all-ones
      $display("[TB] counter wrap");
      pressExec(ADD);
      checkOutput("restart", 1, 1, 0, 0);
      repeat (75) tick();
      checkOutput("cnt_all_ones", 1, 1, 0, 15);
      repeat (5) tick();
      checkOutput("cnt_wrap", 1, 1, 0, 0);
      applyStimulus(1'b1, ADD);
      tick();
      tick();
      applyStimulus(1'b0, ADD);
      repeat (3) tick();
      checkOutput("stop_after_wrap", 0, 0, 0, 1);

`ifdef PHASE_SEQ_STEP_EN
      // single step from idle, then step ignored while running
      $display("[TB] step");
      tick();
      bus.step_btn = 1'b1;
      tick();
      tick();
      bus.step_btn = 1'b0;
      tick();
      checkOutput("step_start", 1, 1, 0, 1);
      repeat (4) tick();
      checkOutput("step_last", 5, 1, 0, 1);
      tick();
      checkOutput("step_done", 0, 0, 0, 2);
      tick();
      pressExec(ADD);
      bus.step_btn = 1'b1;
      tick();
      tick();
      bus.step_btn = 1'b0;
      repeat (3) tick();
      checkOutput("step_ignored", 1, 1, 0, 3);
`endif

      repeat (3) tick();
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Generates the 3-bit `phase` that drives the combinational control decoder, sequencing each instruction through phases 1..NUM_PHASES and holding phase 0 while idle or halted. It sits directly upstream of the control decoder. It starts and stops execution from a synchronised front-panel exec button and detects the HLT instruction in the IR. It also counts retired instructions for debug.

## Interface
- `NUM_PHASES`, default 5: phases per instruction, legal range 2..7.
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk` input 1: system clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `exec_btn` input 1: asynchronous level from the exec button. A rising edge toggles run/stop.
- `instruction` input 16: IR contents, valid from phase 2 onward.
- `phase` output 3: 0 means idle or halted; otherwise 1..NUM_PHASES.
- `running` output 1: high while in RUN.
- `halted` output 1: high while in HALT.
- `inst_cnt` output CNT_W: number of retired instructions.
- `step_btn` input 1: present only with `PHASE_SEQ_STEP_EN`. Asynchronous level; a rising edge executes one instruction.

## Operation
- Reset value of every output is 0: `phase`=0, `running`=0, `halted`=0, `inst_cnt`=0. The internal state resets to IDLE, and all synchroniser flops clear.
- Button inputs:
  - `exec_btn` passes through a 2-flop synchroniser and then a rising-edge detector, producing a 1-cycle `exec_p` pulse.
  - `step_btn` is handled the same way, producing `step_p`.
- HLT decode: `instruction[15:14]==2'b11` and `instruction[7:4]==4'b1111`.
- States and transitions:
  - IDLE (`phase`=0): on `exec_p`, go to RUN with `phase`=1.
  - RUN:
    - `phase` advances by 1 each cycle.
    - At `phase==NUM_PHASES`, `phase` wraps to 1 and `inst_cnt` increments by 1, wrapping from all-ones to 0.
    - If `phase==2` and the instruction is HLT, the next state is HALT with `phase`=0. HLT counts as retired (`inst_cnt`+1).
    - An `exec_p` pulse during RUN sets a `stop_req` flag. At the next `phase==NUM_PHASES`, the sequencer enters IDLE instead of wrapping, clears `stop_req`, and still increments `inst_cnt`.
    - A second `exec_p` while `stop_req` is set clears `stop_req` (toggle semantics).
  - HALT (`phase`=0, `halted`=1): on `exec_p`, go to RUN with `phase`=1 and clear `halted`.
- Simultaneous events:
  - HLT detection at phase 2 together with `exec_p`: HALT wins, and `stop_req` is cleared.
  - `exec_p` on the same cycle as the final-phase wrap with no pending request: `stop_req` is set, and the stop takes effect at the end of the following instruction.
  - `exec_p` on the same cycle as the final-phase wrap with a pending request: the sequencer stops now (IDLE), and the pulse is consumed.
- `rst_n` low mid-instruction: all outputs go to 0 immediately, with no completion of the current instruction.

## Timing
- `exec_btn` first sampled high at edge k: `exec_p` is high during the cycle after edge k+1, and `phase`=1 after edge k+2.
- One instruction takes exactly NUM_PHASES cycles, with no stall input.
- HLT halts the sequencer after phase 2: `phase` is 0 from the following cycle.
- `running`, `halted`, `phase` and `inst_cnt` are registered outputs, with no combinational path from any input.
- The button must stay low for at least 2 cycles between presses for the presses to register as separate edges.

## Configuration
- `PHASE_SEQ_STEP_EN` defined:
  - The `step_btn` port exists.
  - In IDLE or HALT, `step_p` runs exactly one instruction (phases 1..NUM_PHASES, `running`=1), then returns to IDLE with `inst_cnt`+1.
  - HLT during a step enters HALT.
  - `step_p` during RUN is ignored.
  - `step_p` and `exec_p` in the same cycle: exec wins.
- `PHASE_SEQ_STEP_EN` undefined: no `step_btn` port and no step logic. Behaviour is otherwise identical.

## Structure
- Shared package `phase_seq_pkg`:
  - State enum: IDLE, RUN, HALT.
  - `PHASE_IDLE`=3'd0.
  - `OP_ALU`=2'b11 and `ALU_HLT`=4'b1111, shared with the control decoder.
- One sub-module, `btn_edge_sync`: the 2-flop synchroniser plus rising-edge pulse. It is instantiated once for exec and, with `PHASE_SEQ_STEP_EN`, once for step.

## Test plan
- Reset, then one exec press with the instruction set to ADD (16'hC000) → `phase` sequence 1,2,3,4,5,1; `running`=1; `inst_cnt`=1 after the first wrap.
- Running, with the IR switched to HLT (16'hC0F0) before phase 2 → `phase`=0 and `halted`=1 in the cycle after phase 2; `inst_cnt` increments by 1. A further exec press resumes at `phase`=1 with `halted`=0.
- Exec press at phase 3 → the instruction completes through phase 5, then `phase`=0 and `running`=0. Two presses within one instruction → no stop.
- Exec pulse coinciding with HLT detection at phase 2 → HALT, with `stop_req` cleared. The next exec press resumes and does not immediately stop.
- `rst_n` pulsed low at phase 4 with `inst_cnt`=16'h0005 → all outputs 0 asynchronously, state IDLE. With `inst_cnt` preloaded near 16'hFFFF → wraps to 0.
- With `PHASE_SEQ_STEP_EN`: a step press in IDLE → exactly phases 1..5, then `phase`=0, `running`=0, `inst_cnt`+1. A step press during RUN → no effect.
